// File: rtl/comp_pkg.sv
// Shared encodings for the sequential comparator family: FSM states,
// result codes and the digit-count helper used to size the digit index.
package comp_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef logic [1:0] res_t;
  localparam res_t RES_EQ = 2'b00;
  localparam res_t RES_LT = 2'b01;
  localparam res_t RES_GT = 2'b10;

  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice; less-than is
// implied when neither equal nor greater.
module digit_cmp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_gt
);

  assign d_eq = (x == y);
  assign d_gt = (x > y);

endmodule

// File: rtl/seq_compare.sv
// Sequential MSB-first magnitude/equality comparator, DIGIT bits per clock,
// stopping at the first differing digit and reporting one-hot eq/lt/gt.
module seq_compare
  import comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
      $error("seq_compare: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sgn_reg;
  logic [IW-1:0]    idx_reg;
  logic             done_reg;
  logic             eq_reg;
  logic             lt_reg;
  logic             gt_reg;

  logic [DIGIT-1:0] a_dig [N];
  logic [DIGIT-1:0] b_dig [N];
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic             d_eq;
  logic             d_gt;
  res_t             res;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digits
      assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    da = a_dig[idx_reg];
    db = b_dig[idx_reg];
    if (sgn_reg && idx_reg == TOP_IDX) begin
      da[DIGIT-1] = ~da[DIGIT-1];
      db[DIGIT-1] = ~db[DIGIT-1];
    end
  end

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x    (da),
    .y    (db),
    .d_eq (d_eq),
    .d_gt (d_gt)
  );

  always_comb begin
    res = RES_LT;
    if (d_eq)
      res = RES_EQ;
    else if (d_gt)
      res = RES_GT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      eq_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sgn_reg   <= signed_mode;
            idx_reg   <= TOP_IDX;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!d_eq || idx_reg == '0) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
            eq_reg    <= (res == RES_EQ);
            lt_reg    <= (res == RES_LT);
            gt_reg    <= (res == RES_GT);
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = done_reg;
  assign eq   = eq_reg;
  assign lt   = lt_reg;
  assign gt   = gt_reg;

endmodule

// File: tb/tb_seq_compare.sv
// Randomised and directed bench for seq_compare (DIGIT=1 and DIGIT=4
// instances) against an arithmetic reference model.
module tb_seq_compare;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic busy1, done1, eq1, lt1, gt1;
  logic busy4, done4, eq4, lt4, gt4;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  always #5 clk = ~clk;

  seq_compare #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1)
  );

  seq_compare #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy4), .done(done4), .eq(eq4), .lt(lt4), .gt(gt4)
  );

  // Reference: relation from integer compare, latency from highest differing bit.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv,
                                input logic s, input int dg,
                                output logic [2:0] flags, output int k);
    int n;
    int p;
    logic [7:0] diff;
    n = 8 / dg;
    diff = av ^ bv;
    if (diff == 8'h00) begin
      flags = F_EQ;
      k = n;
    end else begin
      if (s) flags = ($signed(av) < $signed(bv)) ? F_LT : F_GT;
      else   flags = (av < bv) ? F_LT : F_GT;
      p = 0;
      for (int i = 0; i < 8; i++) if (diff[i]) p = i;
      k = n - p / dg;
    end
  endfunction

  function automatic logic [2:0] flags_of(input int dg);
    return (dg == 1) ? {eq1, lt1, gt1} : {eq4, lt4, gt4};
  endfunction

  // Drives one start and measures latency/flags/busy; checks are done by callers.
  task automatic run_op(input int dg, input logic [7:0] av, input logic [7:0] bv,
                        input logic s, output int k, output logic [2:0] flags,
                        output int busy_bad);
    logic d;
    logic bz;
    @(negedge clk);
    a = av; b = bv; signed_mode = s;
    if (dg == 1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    a = $urandom; b = $urandom; signed_mode = $urandom;
    k = 0; flags = 3'b000; busy_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      d  = (dg == 1) ? done1 : done4;
      bz = (dg == 1) ? busy1 : busy4;
      if (d) begin
        k = c;
        flags = flags_of(dg);
        if (bz) busy_bad++;
        break;
      end else if (!bz) begin
        busy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy1, done1, eq1, lt1, gt1} !== 5'b0) begin
      bad++;
      $display("FAIL reset_d1: got %b want 00000", {busy1, done1, eq1, lt1, gt1});
    end
    total++;
    if ({busy4, done4, eq4, lt4, gt4} !== 5'b0) begin
      bad++;
      $display("FAIL reset_d4: got %b want 00000", {busy4, done4, eq4, lt4, gt4});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int dg_t [6] = '{1, 1, 1, 1, 4, 4};
    logic [7:0] a_t [6] = '{8'h5A, 8'h80, 8'h80, 8'h10, 8'h3C, 8'hF0};
    logic [7:0] b_t [6] = '{8'h5A, 8'h7F, 8'h7F, 8'h11, 8'h3D, 8'h10};
    logic s_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] f_t [6] = '{F_EQ, F_GT, F_LT, F_LT, F_LT, F_LT};
    int k_t [6] = '{8, 1, 1, 8, 2, 1};
    int k;
    int bb;
    logic [2:0] fl;
    for (int i = 0; i < 6; i++) begin
      run_op(dg_t[i], a_t[i], b_t[i], s_t[i], k, fl, bb);
      total++;
      if (k !== k_t[i] || fl !== f_t[i] || bb != 0) begin
        bad++;
        $display("FAIL directed_%0d: a=%h b=%h s=%0d got k=%0d flags=%b busybad=%0d want k=%0d flags=%b",
                 i, a_t[i], b_t[i], s_t[i], k, fl, bb, k_t[i], f_t[i]);
      end else begin
        $display("directed_%0d a=%h b=%h s=%0d dg=%0d k=%0d flags=%b", i, a_t[i], b_t[i],
                 s_t[i], dg_t[i], k, fl);
      end
    end
  endtask

  task automatic test_ignore_start();
    int k = 0;
    @(negedge clk);
    a = 8'h00; b = 8'h01; signed_mode = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        a = 8'hFF; b = 8'h00; start1 = 1'b1;
      end
      @(posedge clk); #1;
      if (c == 3) start1 = 1'b0;
      if (done1) begin
        k = c;
        break;
      end
    end
    total++;
    if (k !== 8 || {eq1, lt1, gt1} !== F_LT) begin
      bad++;
      $display("FAIL ignore_start: got k=%0d flags=%b want k=8 flags=%b", k, {eq1, lt1, gt1}, F_LT);
    end else begin
      $display("ignore_start k=%0d flags=%b", k, {eq1, lt1, gt1});
    end
  endtask

  task automatic test_reset_midrun();
    int seen_done = 0;
    int k;
    int bb;
    logic [2:0] fl;
    @(negedge clk);
    a = 8'h00; b = 8'h01; signed_mode = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy1, done1, eq1, lt1, gt1} !== 5'b0) begin
      bad++;
      $display("FAIL midrun_reset: got %b want 00000", {busy1, done1, eq1, lt1, gt1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done1) seen_done++;
    end
    total++;
    if (seen_done != 0 || {eq1, lt1, gt1} !== 3'b000) begin
      bad++;
      $display("FAIL midrun_no_done: got dones=%0d flags=%b want dones=0 flags=000",
               seen_done, {eq1, lt1, gt1});
    end
    run_op(1, 8'h00, 8'h01, 1'b0, k, fl, bb);
    total++;
    if (k !== 8 || fl !== F_LT || bb != 0) begin
      bad++;
      $display("FAIL after_reset: got k=%0d flags=%b busybad=%0d want k=8 flags=%b", k, fl, bb, F_LT);
    end else begin
      $display("after_reset k=%0d flags=%b", k, fl);
    end
  endtask

  task automatic test_random();
    int k;
    int bb;
    int ek;
    logic [2:0] fl;
    logic [2:0] ef;
    logic [7:0] av;
    logic [7:0] bv;
    logic s;
    int dg;
    for (int i = 0; i < 40; i++) begin
      dg = (i % 2 == 0) ? 1 : 4;
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? av : 8'($urandom);
      if ($urandom_range(0, 3) == 0) bv = av ^ (8'h01 << $urandom_range(0, 7));
      s = $urandom;
      model(av, bv, s, dg, ef, ek);
      run_op(dg, av, bv, s, k, fl, bb);
      total++;
      if (k !== ek || fl !== ef || bb != 0) begin
        bad++;
        $display("FAIL random_%0d: dg=%0d a=%h b=%h s=%0d got k=%0d flags=%b busybad=%0d want k=%0d flags=%b",
                 i, dg, av, bv, s, k, fl, bb, ek, ef);
      end else begin
        $display("random_%0d dg=%0d a=%h b=%h s=%0d k=%0d flags=%b", i, dg, av, bv, s, k, fl);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    int dones = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h00; signed_mode = 1'b0; start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      exp_done = ((c % 9) == 8);
      total++;
      if (done1 !== exp_done || busy1 !== !exp_done || (exp_done && {eq1, lt1, gt1} !== F_GT)) begin
        bad++;
        $display("FAIL back_to_back_c%0d: got done=%b busy=%b flags=%b want done=%b busy=%b",
                 c, done1, busy1, {eq1, lt1, gt1}, exp_done, !exp_done);
      end
      if (done1) dones++;
    end
    @(negedge clk);
    start1 = 1'b0;
    $display("back_to_back dones=%0d", dones);
    repeat (10) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
